vga_timing_gen: RTL and testbench
=================================

VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001 Parameter CLK_DIV, default 4: system clocks per pixel tick; legal values are 1 and above.
REQ-002 Parameter H_ACTIVE, default 640: visible pixels per line.
REQ-003 Parameter H_FP, default 16: horizontal front porch, in ticks.
REQ-004 Parameter H_SYNC, default 96: horizontal sync width, in ticks.
REQ-005 Parameter H_BP, default 48: horizontal back porch, in ticks.
REQ-006 Parameter V_ACTIVE, default 480: visible lines per frame.
REQ-007 Parameter V_FP, default 10: vertical front porch, in lines.
REQ-008 Parameter V_SYNC, default 2: vertical sync width, in lines.
REQ-009 Parameter V_BP, default 33: vertical back porch, in lines.
REQ-010 Parameter H_POL, default 0: hsync asserted level (0 = active low).
REQ-011 Parameter V_POL, default 0: vsync asserted level (0 = active low).
REQ-012 Parameter CW, default 11: counter width; H_TOTAL-1 and V_TOTAL-1 shall fit in CW bits.
REQ-013 The block has one clock; reset is synchronous and active-high.
REQ-014 clk, input, 1: system clock; every flop is on its rising edge.
REQ-015 rst, input, 1: synchronous active-high reset.
REQ-016 en, input, 1: timing enable; when low, every counter and output holds.
REQ-017 hcounter, output, CW: current pixel column, 0..H_TOTAL-1, registered.
REQ-018 vcounter, output, CW: current line, 0..V_TOTAL-1, registered.
REQ-019 hsync, output, 1: horizontal sync, registered.
REQ-020 vsync, output, 1: vertical sync, registered.
REQ-021 blank, output, 1: high outside the visible region, registered.
REQ-022 pix_tick, output, 1: one-clk pulse on every clk edge where the counters advance.
REQ-023 line_start, output, 1: one-clk pulse when hcounter becomes 0.
REQ-024 frame_start, output, 1: one-clk pulse when hcounter and vcounter both become 0.

Function
REQ-025 H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP and V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP.
REQ-026 The prescaler counts 0..CLK_DIV-1 while en=1; at CLK_DIV-1 it wraps to 0 and a tick occurs.
REQ-027 With CLK_DIV=1 a tick occurs on every enabled clk edge.
REQ-028 On a tick, hcounter increments; at H_TOTAL-1 it wraps to 0.
REQ-029 vcounter increments only on a tick where hcounter wraps; at V_TOTAL-1 it wraps to 0.
REQ-030 All registered outputs update on the tick edge and reflect the new counter values, so no output lags the counters.
REQ-031 hsync = H_POL when H_ACTIVE+H_FP <= hcounter < H_ACTIVE+H_FP+H_SYNC, and ~H_POL otherwise.
REQ-032 vsync = V_POL when V_ACTIVE+V_FP <= vcounter < V_ACTIVE+V_FP+V_SYNC, and ~V_POL otherwise; vsync changes only together with hcounter=0.
REQ-033 blank = 0 exactly when hcounter < H_ACTIVE and vcounter < V_ACTIVE.
REQ-034 pix_tick, line_start and frame_start are high only on the clk cycle after the tick edge and low otherwise.
REQ-035 When en=0, the prescaler and counters freeze, the three pulses are 0, and resuming continues from the frozen state with no lost or extra tick.
REQ-036 When rst and en are both high, rst wins.

Reset
REQ-037 rst=1 at a clk edge sets the prescaler to 0, hcounter to H_TOTAL-1 and vcounter to V_TOTAL-1.
REQ-038 rst=1 also sets hsync=~H_POL, vsync=~V_POL, blank=1, and pix_tick=line_start=frame_start=0.
REQ-039 The first tick after reset therefore wraps to (0,0) and asserts frame_start.
REQ-040 rst asserted mid-frame takes effect at the next clk edge regardless of prescaler phase.

Verification
REQ-041 Defaults, rst for 2 clks, then en=1 -> 4 clks after rst falls: hcounter=0, vcounter=0, frame_start=line_start=pix_tick=1, blank=0.
REQ-042 Defaults, free-run -> hsync low for hcounter 656..751 (384 clks), line period 3200 clks, line_start every 3200 clks.
REQ-043 Defaults -> vsync low for vcounter 490..491 (6400 clks), frame_start period 1,680,000 clks, blank=1 for every vcounter >= 480.
REQ-044 en held low for 37 clks mid-line -> counters and outputs frozen with no pulses; after release the next tick increments hcounter by exactly 1.
REQ-045 rst pulsed at hcounter=300, vcounter=200 -> next edge shows (H_TOTAL-1, V_TOTAL-1) with outputs at reset values; the first following tick gives frame_start.
REQ-046 CLK_DIV=1, H_POL=1, V_POL=1, 800x600 timing (40/128/88 and 1/4/23) -> pix_tick high every clk, hsync high for 128 ticks, vsync high for 4 lines, H_TOTAL=1056, V_TOTAL=628.

Source files
------------

// File: rtl/vga_timing_gen_if.sv
// Bundle of timing-generator signals. The generator sits on the slave side:
// it receives the enable and drives counters, syncs, blank and pulses.
interface vga_timing_gen_if #(
    parameter int CW = 11
);
    logic          en;
    logic [CW-1:0] hcounter;
    logic [CW-1:0] vcounter;
    logic          hsync;
    logic          vsync;
    logic          blank;
    logic          pix_tick;
    logic          line_start;
    logic          frame_start;

    modport master (
        output en,
        input  hcounter, vcounter, hsync, vsync, blank,
        input  pix_tick, line_start, frame_start
    );

    modport slave (
        input  en,
        output hcounter, vcounter, hsync, vsync, blank,
        output pix_tick, line_start, frame_start
    );
endinterface

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator. A prescaler turns clk into pixel ticks; on each
// tick the column/line counters advance and every registered output is loaded
// from the *next* counter values so nothing lags the counters. Reset parks the
// counters on the last pixel of the frame so the first tick lands on (0,0).
module vga_timing_gen #(
    parameter int CLK_DIV  = 4,
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter bit H_POL    = 1'b0,
    parameter bit V_POL    = 1'b0,
    parameter int CW       = 11
) (
    input  logic                  clk,
    input  logic                  rst,
    vga_timing_gen_if.slave       vga
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int PW      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic [PW-1:0] r_presc;
    logic [CW-1:0] r_hcnt;
    logic [CW-1:0] r_vcnt;
    logic          r_hsync;
    logic          r_vsync;
    logic          r_blank;
    logic          r_pix_tick;
    logic          r_line_start;
    logic          r_frame_start;

    logic          w_tick;
    logic          w_h_wrap;
    logic [CW-1:0] w_h_next;
    logic [CW-1:0] w_v_next;
    logic          w_hs_act;
    logic          w_vs_act;
    logic          w_visible;

    // Next counter values and the output levels they imply.
    always_comb begin
        w_tick   = vga.en && (r_presc == PW'(CLK_DIV - 1));
        w_h_wrap = (r_hcnt == CW'(H_TOTAL - 1));
        w_h_next = w_h_wrap ? '0 : r_hcnt + CW'(1);
        w_v_next = r_vcnt;
        if (w_h_wrap) begin
            w_v_next = (r_vcnt == CW'(V_TOTAL - 1)) ? '0 : r_vcnt + CW'(1);
        end
        w_hs_act  = (w_h_next >= CW'(H_ACTIVE + H_FP)) &&
                    (w_h_next <  CW'(H_ACTIVE + H_FP + H_SYNC));
        w_vs_act  = (w_v_next >= CW'(V_ACTIVE + V_FP)) &&
                    (w_v_next <  CW'(V_ACTIVE + V_FP + V_SYNC));
        w_visible = (w_h_next < CW'(H_ACTIVE)) && (w_v_next < CW'(V_ACTIVE));
    end

    // Prescaler: counts enabled clocks, wraps on the tick.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_presc <= '0;
        end else if (vga.en) begin
            r_presc <= w_tick ? '0 : r_presc + PW'(1);
        end
    end

    // Column/line counters advance only on a tick.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_hcnt <= CW'(H_TOTAL - 1);
            r_vcnt <= CW'(V_TOTAL - 1);
        end else if (w_tick) begin
            r_hcnt <= w_h_next;
            r_vcnt <= w_v_next;
        end
    end

    // Syncs and blank load with the counters; pulses mark the tick edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_hsync       <= ~H_POL;
            r_vsync       <= ~V_POL;
            r_blank       <= 1'b1;
            r_pix_tick    <= 1'b0;
            r_line_start  <= 1'b0;
            r_frame_start <= 1'b0;
        end else begin
            r_pix_tick    <= w_tick;
            r_line_start  <= w_tick && (w_h_next == '0);
            r_frame_start <= w_tick && (w_h_next == '0) && (w_v_next == '0);
            if (w_tick) begin
                r_hsync <= w_hs_act ? H_POL : ~H_POL;
                r_vsync <= w_vs_act ? V_POL : ~V_POL;
                r_blank <= ~w_visible;
            end
        end
    end

    assign vga.hcounter    = r_hcnt;
    assign vga.vcounter    = r_vcnt;
    assign vga.hsync       = r_hsync;
    assign vga.vsync       = r_vsync;
    assign vga.blank       = r_blank;
    assign vga.pix_tick    = r_pix_tick;
    assign vga.line_start  = r_line_start;
    assign vga.frame_start = r_frame_start;
endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen: default 640x480 timing, an 800x600
// single-clock-per-pixel positive-polarity variant, and a tiny raster used
// for frame-level behaviour that would take too long at full size.
module tb_vga_timing_gen;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   vectors = 0;
    int   miscompares = 0;

    always #5 clk = ~clk;

    vga_timing_gen_if #(.CW(11)) if_def ();
    vga_timing_gen_if #(.CW(11)) if_svga ();
    vga_timing_gen_if #(.CW(5))  if_sml ();

    vga_timing_gen u_def (
        .clk (clk),
        .rst (rst),
        .vga (if_def)
    );

    vga_timing_gen #(
        .CLK_DIV(1), .H_ACTIVE(800), .H_FP(40), .H_SYNC(128), .H_BP(88),
        .V_ACTIVE(600), .V_FP(1), .V_SYNC(4), .V_BP(23),
        .H_POL(1'b1), .V_POL(1'b1), .CW(11)
    ) u_svga (
        .clk (clk),
        .rst (rst),
        .vga (if_svga)
    );

    // 16 x 8 raster, 2 clks per pixel: line = 32 clks, frame = 256 clks.
    vga_timing_gen #(
        .CLK_DIV(2), .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
        .H_POL(1'b0), .V_POL(1'b0), .CW(5)
    ) u_sml (
        .clk (clk),
        .rst (rst),
        .vga (if_sml)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        if_def.en = 1'b0; if_svga.en = 1'b0; if_sml.en = 1'b0;
        step(); step();
        vectors++; if (if_def.hcounter !== 11'd799) begin miscompares++; $display("FAIL rst_def_h: got %0d want 799", if_def.hcounter); end
        vectors++; if (if_def.vcounter !== 11'd524) begin miscompares++; $display("FAIL rst_def_v: got %0d want 524", if_def.vcounter); end
        vectors++; if ({if_def.hsync, if_def.vsync, if_def.blank} !== 3'b111) begin miscompares++; $display("FAIL rst_def_lvls: got %b want 111", {if_def.hsync, if_def.vsync, if_def.blank}); end
        vectors++; if ({if_def.pix_tick, if_def.line_start, if_def.frame_start} !== 3'b000) begin miscompares++; $display("FAIL rst_def_pulses: got %b want 000", {if_def.pix_tick, if_def.line_start, if_def.frame_start}); end
        vectors++; if (if_svga.hcounter !== 11'd1055) begin miscompares++; $display("FAIL rst_svga_h: got %0d want 1055", if_svga.hcounter); end
        vectors++; if (if_svga.vcounter !== 11'd627) begin miscompares++; $display("FAIL rst_svga_v: got %0d want 627", if_svga.vcounter); end
        vectors++; if ({if_svga.hsync, if_svga.vsync, if_svga.blank} !== 3'b001) begin miscompares++; $display("FAIL rst_svga_lvls: got %b want 001", {if_svga.hsync, if_svga.vsync, if_svga.blank}); end
        vectors++; if ({if_sml.hcounter, if_sml.vcounter} !== {5'd15, 5'd7}) begin miscompares++; $display("FAIL rst_sml_hv: got %0d,%0d want 15,7", if_sml.hcounter, if_sml.vcounter); end
    endtask

    task automatic test_first_tick();
        int early;
        early = 0;
        rst = 1'b0;
        if_def.en = 1'b1; if_svga.en = 1'b1; if_sml.en = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            step();
            if (if_def.pix_tick !== 1'b0 || if_def.hcounter !== 11'd799) early++;
        end
        vectors++; if (early != 0) begin miscompares++; $display("FAIL first_tick_early: got %0d early cycles want 0", early); end
        step();
        vectors++; if ({if_def.hcounter, if_def.vcounter} !== {11'd0, 11'd0}) begin miscompares++; $display("FAIL first_tick_hv: got %0d,%0d want 0,0", if_def.hcounter, if_def.vcounter); end
        vectors++; if ({if_def.frame_start, if_def.line_start, if_def.pix_tick} !== 3'b111) begin miscompares++; $display("FAIL first_tick_pulses: got %b want 111", {if_def.frame_start, if_def.line_start, if_def.pix_tick}); end
        vectors++; if ({if_def.blank, if_def.hsync, if_def.vsync} !== 3'b011) begin miscompares++; $display("FAIL first_tick_lvls: got %b want 011", {if_def.blank, if_def.hsync, if_def.vsync}); end
    endtask

    task automatic test_line();
        int low_cnt, first_low, last_low, ls_cnt, ls_pos, pt_cnt, blank_cnt, fs_cnt;
        low_cnt = 0; first_low = -1; last_low = -1; ls_cnt = 0; ls_pos = -1;
        pt_cnt = 0; blank_cnt = 0; fs_cnt = 0;
        for (int c = 1; c <= 3200; c++) begin
            step();
            if (if_def.hsync == 1'b0) begin
                low_cnt++;
                if (first_low < 0) first_low = int'(if_def.hcounter);
                last_low = int'(if_def.hcounter);
            end
            if (if_def.line_start) begin ls_cnt++; ls_pos = c; end
            if (if_def.pix_tick) pt_cnt++;
            if (if_def.blank) blank_cnt++;
            if (if_def.frame_start) fs_cnt++;
        end
        vectors++; if (low_cnt != 384) begin miscompares++; $display("FAIL hsync_width: got %0d clks want 384", low_cnt); end
        vectors++; if (first_low != 656 || last_low != 751) begin miscompares++; $display("FAIL hsync_span: got %0d..%0d want 656..751", first_low, last_low); end
        vectors++; if (ls_cnt != 1 || ls_pos != 3200) begin miscompares++; $display("FAIL line_period: got %0d pulses at %0d want 1 at 3200", ls_cnt, ls_pos); end
        vectors++; if (pt_cnt != 800) begin miscompares++; $display("FAIL tick_rate: got %0d ticks want 800", pt_cnt); end
        vectors++; if (blank_cnt != 640) begin miscompares++; $display("FAIL hblank_width: got %0d clks want 640", blank_cnt); end
        vectors++; if (fs_cnt != 0) begin miscompares++; $display("FAIL no_frame_start: got %0d want 0", fs_cnt); end
        vectors++; if ({if_def.hcounter, if_def.vcounter} !== {11'd0, 11'd1}) begin miscompares++; $display("FAIL line_wrap: got %0d,%0d want 0,1", if_def.hcounter, if_def.vcounter); end
    endtask

    task automatic test_enable();
        int frz_err, gap;
        frz_err = 0; gap = 0;
        for (int i = 0; i < 402; i++) step();
        vectors++; if ({if_def.hcounter, if_def.vcounter, if_def.pix_tick} !== {11'd100, 11'd1, 1'b0}) begin miscompares++; $display("FAIL pre_freeze: got %0d,%0d,%b want 100,1,0", if_def.hcounter, if_def.vcounter, if_def.pix_tick); end
        if_def.en = 1'b0;
        for (int i = 0; i < 37; i++) begin
            step();
            if (if_def.hcounter !== 11'd100 || if_def.vcounter !== 11'd1) frz_err++;
            if ({if_def.pix_tick, if_def.line_start, if_def.frame_start} !== 3'b000) frz_err++;
            if ({if_def.hsync, if_def.vsync, if_def.blank} !== 3'b110) frz_err++;
        end
        vectors++; if (frz_err != 0) begin miscompares++; $display("FAIL freeze: got %0d disturbed cycles want 0", frz_err); end
        if_def.en = 1'b1;
        step();
        vectors++; if ({if_def.hcounter, if_def.pix_tick} !== {11'd100, 1'b0}) begin miscompares++; $display("FAIL resume_phase: got %0d,%b want 100,0", if_def.hcounter, if_def.pix_tick); end
        step();
        vectors++; if ({if_def.hcounter, if_def.pix_tick} !== {11'd101, 1'b1}) begin miscompares++; $display("FAIL resume_tick: got %0d,%b want 101,1", if_def.hcounter, if_def.pix_tick); end
        do begin step(); gap++; end while (if_def.pix_tick !== 1'b1 && gap < 16);
        vectors++; if (gap != 4 || if_def.hcounter !== 11'd102) begin miscompares++; $display("FAIL resume_gap: got gap %0d h %0d want 4,102", gap, if_def.hcounter); end
    endtask

    task automatic test_mid_reset();
        int waited, early;
        waited = 0; early = 0;
        while (if_def.hcounter !== 11'd300 && waited < 2000) begin step(); waited++; end
        vectors++; if (if_def.hcounter !== 11'd300) begin miscompares++; $display("FAIL reach_h300: got %0d want 300 (timeout)", if_def.hcounter); end
        step();
        rst = 1'b1;
        step();
        vectors++; if ({if_def.hcounter, if_def.vcounter} !== {11'd799, 11'd524}) begin miscompares++; $display("FAIL midrst_hv: got %0d,%0d want 799,524", if_def.hcounter, if_def.vcounter); end
        vectors++; if ({if_def.hsync, if_def.vsync, if_def.blank, if_def.pix_tick, if_def.line_start, if_def.frame_start} !== 6'b111000) begin miscompares++; $display("FAIL midrst_outs: got %b want 111000", {if_def.hsync, if_def.vsync, if_def.blank, if_def.pix_tick, if_def.line_start, if_def.frame_start}); end
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            if (if_def.pix_tick !== 1'b0) early++;
        end
        vectors++; if (early != 0) begin miscompares++; $display("FAIL midrst_early: got %0d ticks want 0", early); end
        step();
        vectors++; if ({if_def.frame_start, if_def.hcounter, if_def.vcounter} !== {1'b1, 11'd0, 11'd0}) begin miscompares++; $display("FAIL midrst_frame: got %b,%0d,%0d want 1,0,0", if_def.frame_start, if_def.hcounter, if_def.vcounter); end
    endtask

    task automatic test_vertical();
        int waited, vs_low, first_v, last_v, vs_bad_h, fs_cnt, fs_first, fs_last;
        int blank_bad, vis_cnt, v_max;
        logic prev_vs;
        waited = 0; vs_low = 0; first_v = -1; last_v = -1; vs_bad_h = 0;
        fs_cnt = 0; fs_first = -1; fs_last = -1; blank_bad = 0; vis_cnt = 0; v_max = 0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        do begin step(); waited++; end while (if_sml.frame_start !== 1'b1 && waited < 8);
        vectors++; if (waited != 2) begin miscompares++; $display("FAIL sml_first_frame: got %0d clks want 2", waited); end
        prev_vs = if_sml.vsync;
        for (int c = 1; c <= 512; c++) begin
            step();
            if (c <= 256) begin
                if (if_sml.vsync == 1'b0) begin
                    vs_low++;
                    if (first_v < 0) first_v = int'(if_sml.vcounter);
                    last_v = int'(if_sml.vcounter);
                end
                if (if_sml.blank == 1'b0) vis_cnt++;
            end
            if (if_sml.vsync !== prev_vs && if_sml.hcounter !== 5'd0) vs_bad_h++;
            prev_vs = if_sml.vsync;
            if (if_sml.vcounter >= 5'd4 && if_sml.blank !== 1'b1) blank_bad++;
            if (int'(if_sml.vcounter) > v_max) v_max = int'(if_sml.vcounter);
            if (if_sml.frame_start) begin
                fs_cnt++;
                if (fs_first < 0) fs_first = c;
                fs_last = c;
            end
        end
        vectors++; if (vs_low != 64) begin miscompares++; $display("FAIL vsync_width: got %0d clks want 64", vs_low); end
        vectors++; if (first_v != 5 || last_v != 6) begin miscompares++; $display("FAIL vsync_span: got %0d..%0d want 5..6", first_v, last_v); end
        vectors++; if (vs_bad_h != 0) begin miscompares++; $display("FAIL vsync_align: got %0d off-column edges want 0", vs_bad_h); end
        vectors++; if (fs_cnt != 2 || fs_first != 256 || fs_last != 512) begin miscompares++; $display("FAIL frame_period: got %0d at %0d/%0d want 2 at 256/512", fs_cnt, fs_first, fs_last); end
        vectors++; if (blank_bad != 0) begin miscompares++; $display("FAIL vblank: got %0d unblanked clks want 0", blank_bad); end
        vectors++; if (vis_cnt != 64) begin miscompares++; $display("FAIL visible_area: got %0d clks want 64", vis_cnt); end
        vectors++; if (v_max != 7) begin miscompares++; $display("FAIL v_total: got max %0d want 7", v_max); end
    endtask

    task automatic test_svga();
        int pt_cnt, hs_high, first_h, last_h, ls_cnt, ls_pos;
        pt_cnt = 0; hs_high = 0; first_h = -1; last_h = -1; ls_cnt = 0; ls_pos = -1;
        rst = 1'b1;
        step();
        rst = 1'b0;
        step();
        vectors++; if ({if_svga.frame_start, if_svga.hcounter, if_svga.vcounter, if_svga.hsync} !== {1'b1, 11'd0, 11'd0, 1'b0}) begin miscompares++; $display("FAIL svga_first: got %b,%0d,%0d,%b want 1,0,0,0", if_svga.frame_start, if_svga.hcounter, if_svga.vcounter, if_svga.hsync); end
        for (int c = 1; c <= 1056; c++) begin
            step();
            if (if_svga.pix_tick) pt_cnt++;
            if (if_svga.hsync == 1'b1) begin
                hs_high++;
                if (first_h < 0) first_h = int'(if_svga.hcounter);
                last_h = int'(if_svga.hcounter);
            end
            if (if_svga.line_start) begin ls_cnt++; ls_pos = c; end
        end
        vectors++; if (pt_cnt != 1056) begin miscompares++; $display("FAIL svga_tick_every_clk: got %0d want 1056", pt_cnt); end
        vectors++; if (hs_high != 128) begin miscompares++; $display("FAIL svga_hsync_width: got %0d want 128", hs_high); end
        vectors++; if (first_h != 840 || last_h != 967) begin miscompares++; $display("FAIL svga_hsync_span: got %0d..%0d want 840..967", first_h, last_h); end
        vectors++; if (ls_cnt != 1 || ls_pos != 1056) begin miscompares++; $display("FAIL svga_h_total: got %0d pulses at %0d want 1 at 1056", ls_cnt, ls_pos); end
        vectors++; if ({if_svga.hcounter, if_svga.vcounter, if_svga.vsync} !== {11'd0, 11'd1, 1'b0}) begin miscompares++; $display("FAIL svga_line_wrap: got %0d,%0d,%b want 0,1,0", if_svga.hcounter, if_svga.vcounter, if_svga.vsync); end
    endtask

    initial begin
        if_def.en = 1'b0; if_svga.en = 1'b0; if_sml.en = 1'b0;
        test_reset();
        test_first_tick();
        test_line();
        test_enable();
        test_mid_reset();
        test_vertical();
        test_svga();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
